// File: rtl/arr_proc_pkg.sv
// rtl/arr_proc_pkg.sv - shared enums for the array processing unit
package arr_proc_pkg;

  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_INV  = 2'd1,
    MODE_ROTL = 2'd2,
    MODE_POPC = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/arr_rotl1.sv
// rtl/arr_rotl1.sv - combinational rotate-left-by-one of a WIDTH-bit word
module arr_rotl1 #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = {a[WIDTH-2:0], a[WIDTH-1]};

endmodule

// File: rtl/arr_proc_unit.sv
// rtl/arr_proc_unit.sv - handshaked array datapath: pass, invert, rotate-left, popcount
module arr_proc_unit
  import arr_proc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] arr,
  input  logic [1:0]       mode,
  input  logic [AMT_W-1:0] amt,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int PC_W = $clog2(WIDTH + 1);
  // Popcount walks every bit, so its last BUSY cycle has index WIDTH-1.
  localparam logic [AMT_W-1:0] TERM_POPC = AMT_W'(WIDTH - 1);

  state_e            state_q, state_d;
  mode_e             mode_q,  mode_d;
  logic [AMT_W-1:0]  amt_q,   amt_d;
  logic [AMT_W-1:0]  cnt_q,   cnt_d;
  logic [WIDTH-1:0]  work_q,  work_d;
  logic [PC_W-1:0]   pop_q,   pop_d;
  logic [WIDTH-1:0]  out_q,   out_d;

  logic [WIDTH-1:0]  work_rot;
  logic [PC_W-1:0]   pop_nxt;
  logic [AMT_W-1:0]  term;
  logic [WIDTH-1:0]  result;

  arr_rotl1 #(.WIDTH(WIDTH)) u_rotl1 (
    .a (work_q),
    .y (work_rot)
  );

  assign pop_nxt = pop_q + PC_W'(work_q[0]);

  // Terminal BUSY-cycle index and the final result, both from the latched request.
  // The result folds in the current cycle's step so out lands on the BUSY->DONE edge.
  always_comb begin
    term   = '0;
    result = work_q;
    case (mode_q)
      MODE_PASS: result = work_q;
      MODE_INV:  result = ~work_q;
      MODE_ROTL: begin
        term   = (amt_q == '0) ? '0 : amt_q - AMT_W'(1);
        result = (amt_q == '0) ? work_q : work_rot;
      end
      MODE_POPC: begin
        term   = TERM_POPC;
        result = WIDTH'(pop_nxt);
      end
      default: result = work_q;
    endcase
  end

  // Next-state logic: accept in IDLE, step the working register in BUSY, hold in DONE.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    amt_d   = amt_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    pop_d   = pop_q;
    out_d   = out_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d = ST_BUSY;
          mode_d  = mode_e'(mode);
          amt_d   = amt;
          work_d  = arr;
          pop_d   = '0;
          cnt_d   = '0;
        end
      end
      ST_BUSY: begin
        if (mode_q == MODE_ROTL && amt_q != '0) begin
          work_d = work_rot;
        end else if (mode_q == MODE_POPC) begin
          work_d = work_q >> 1;
          pop_d  = pop_nxt;
        end
        if (cnt_q == term) begin
          state_d = ST_DONE;
          out_d   = result;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AMT_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset wins over every handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_PASS;
      amt_q   <= '0;
      cnt_q   <= '0;
      work_q  <= '0;
      pop_q   <= '0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      amt_q   <= amt_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      pop_q   <= pop_d;
      out_q   <= out_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_q;

endmodule

// File: tb/tb_arr_proc_unit.sv
// tb/tb_arr_proc_unit.sv - directed table-driven bench for arr_proc_unit
module tb_arr_proc_unit;

  logic       clk = 1'b0;
  logic       rst;

  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [3:0] arr4, out4;
  logic [1:0] mode4, amt4;

  logic       in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0] arr8, out8;
  logic [1:0] mode8;
  logic [2:0] amt8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arr_proc_unit #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .arr(arr4), .mode(mode4), .amt(amt4),
    .out(out4), .out_valid(out_valid4), .out_ready(out_ready4)
  );

  arr_proc_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .arr(arr8), .mode(mode8), .amt(amt8),
    .out(out8), .out_valid(out_valid8), .out_ready(out_ready8)
  );

  typedef struct {
    string      name;
    logic [1:0] mode;
    logic [3:0] arr;
    logic [1:0] amt;
    logic [3:0] exp_out;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run4(input string name, input logic [1:0] m, input logic [3:0] a,
                      input logic [1:0] am, input logic [3:0] e, input int l);
    int lat;
    @(negedge clk);
    check({name, " in_ready"}, 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1; mode4 = m; arr4 = a; amt4 = am; out_ready4 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid4 = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); @(negedge clk);
      lat++;
    end while (!out_valid4 && lat < 40);
    check({name, " out_valid"}, 32'(out_valid4), 32'd1);
    check({name, " latency"}, 32'(lat), 32'(l));
    check({name, " out"}, 32'(out4), 32'(e));
    @(posedge clk); @(negedge clk);
    check({name, " idle out_valid"}, 32'(out_valid4), 32'd0);
    check({name, " idle in_ready"}, 32'(in_ready4), 32'd1);
    check({name, " out held"}, 32'(out4), 32'(e));
  endtask

  initial begin
    int lat;
    vecs[0] = '{"pass_0111",  2'd0, 4'b0111, 2'd0, 4'b0111, 1};
    vecs[1] = '{"inv_0111",   2'd1, 4'b0111, 2'd0, 4'b1000, 1};
    vecs[2] = '{"rotl3_0111", 2'd2, 4'b0111, 2'd3, 4'b1011, 3};
    vecs[3] = '{"rotl0_0111", 2'd2, 4'b0111, 2'd0, 4'b0111, 1};
    vecs[4] = '{"rotl1_0111", 2'd2, 4'b0111, 2'd1, 4'b1110, 1};
    vecs[5] = '{"rotl2_1000", 2'd2, 4'b1000, 2'd2, 4'b0010, 2};
    vecs[6] = '{"popc_0111",  2'd3, 4'b0111, 2'd0, 4'b0011, 4};
    vecs[7] = '{"popc_1111",  2'd3, 4'b1111, 2'd2, 4'b0100, 4};
    vecs[8] = '{"popc_0000",  2'd3, 4'b0000, 2'd0, 4'b0000, 4};
    vecs[9] = '{"inv_0000",   2'd1, 4'b0000, 2'd1, 4'b1111, 1};

    rst = 1'b1;
    in_valid4 = 0; out_ready4 = 0; arr4 = 0; mode4 = 0; amt4 = 0;
    in_valid8 = 0; out_ready8 = 0; arr8 = 0; mode8 = 0; amt8 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out", 32'(out4), 32'd0);
    check("reset out_valid", 32'(out_valid4), 32'd0);
    check("reset in_ready", 32'(in_ready4), 32'd1);
    check("reset8 out", 32'(out8), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run4(vecs[i].name, vecs[i].mode, vecs[i].arr, vecs[i].amt, vecs[i].exp_out, vecs[i].exp_lat);
    end

    // Stall in DONE with out_ready low while new requests are offered.
    @(negedge clk);
    in_valid4 = 1'b1; mode4 = 2'd3; arr4 = 4'b0111; amt4 = 2'd0; out_ready4 = 1'b0;
    @(posedge clk); @(negedge clk);
    in_valid4 = 1'b1; mode4 = 2'd0; arr4 = 4'b1111;
    check("stall busy in_ready", 32'(in_ready4), 32'd0);
    repeat (4) begin @(posedge clk); @(negedge clk); end
    check("stall out_valid", 32'(out_valid4), 32'd1);
    check("stall out", 32'(out4), 32'd3);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); @(negedge clk);
      check("stall hold out_valid", 32'(out_valid4), 32'd1);
      check("stall hold out", 32'(out4), 32'd3);
      check("stall hold in_ready", 32'(in_ready4), 32'd0);
    end
    in_valid4 = 1'b0; out_ready4 = 1'b1;
    @(posedge clk); @(negedge clk);
    check("stall release in_ready", 32'(in_ready4), 32'd1);
    check("stall release out_valid", 32'(out_valid4), 32'd0);
    check("stall release out", 32'(out4), 32'd3);

    // Reset on the 2nd BUSY cycle of a popcount, with handshakes asserted alongside.
    @(negedge clk);
    in_valid4 = 1'b1; mode4 = 2'd3; arr4 = 4'b0111; out_ready4 = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid4 = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1; in_valid4 = 1'b1; mode4 = 2'd0; arr4 = 4'b1111;
    @(posedge clk); @(negedge clk);
    check("midrst in_ready", 32'(in_ready4), 32'd1);
    check("midrst out", 32'(out4), 32'd0);
    check("midrst out_valid", 32'(out_valid4), 32'd0);
    rst = 1'b0; in_valid4 = 1'b0;
    run4("post_rst_pass_1010", 2'd0, 4'b1010, 2'd0, 4'b1010, 1);

    // WIDTH=8 popcount of all-ones and a full-span rotate.
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      in_valid8 = 1'b1; out_ready8 = 1'b1;
      mode8 = (t == 0) ? 2'd3 : 2'd2;
      arr8  = (t == 0) ? 8'hFF : 8'h01;
      amt8  = (t == 0) ? 3'd0 : 3'd7;
      @(posedge clk); @(negedge clk);
      in_valid8 = 1'b0;
      lat = 0;
      do begin
        @(posedge clk); @(negedge clk);
        lat++;
      end while (!out_valid8 && lat < 40);
      check("w8 out_valid", 32'(out_valid8), 32'd1);
      check("w8 latency", 32'(lat), (t == 0) ? 32'd8 : 32'd7);
      check("w8 out", 32'(out8), (t == 0) ? 32'h08 : 32'h80);
      @(posedge clk); @(negedge clk);
      check("w8 idle in_ready", 32'(in_ready8), 32'd1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
